// File: rtl/sd_spi_block_rx_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sd_spi_block_rx_if : control, SD data line and byte-sink bundle       |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
interface sd_spi_block_rx_if;
  logic        start;
  logic        sample_en;
  logic        sd_data0;
  logic        busy;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [8:0]  byte_index;
  logic        done;
  logic [1:0]  status;
  logic [15:0] crc_rx;

  modport master (
    output start, sample_en, sd_data0,
    input  busy, byte_data, byte_valid, byte_index, done, status, crc_rx
  );

  modport slave (
    input  start, sample_en, sd_data0,
    output busy, byte_data, byte_valid, byte_index, done, status, crc_rx
  );
endinterface
`default_nettype wire

// File: rtl/sd_spi_block_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sd_spi_block_rx : SPI-mode SD single-block receiver (token, payload,  |
// | CRC16). Define SD_RX_CRC_CHECK_EN to enable the CRC compare.          |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module sd_spi_block_rx #(
  parameter int BLOCK_BYTES   = 512,
  parameter int TOKEN_TIMEOUT = 800
) (
  input  logic             clk,
  input  logic             rst_n,
  sd_spi_block_rx_if.slave rx
);

  localparam int                  C_HUNT_W      = $clog2(TOKEN_TIMEOUT + 1);
  localparam logic [C_HUNT_W-1:0] C_HUNT_SAT    = C_HUNT_W'(TOKEN_TIMEOUT);
  localparam logic [C_HUNT_W-1:0] C_HUNT_LAST   = C_HUNT_W'(TOKEN_TIMEOUT - 1);
  localparam logic [8:0]          C_LAST_BYTE   = 9'(BLOCK_BYTES - 1);
  localparam logic [7:0]          C_START_TOKEN = 8'hFE;
  localparam logic [1:0]          C_ST_OK       = 2'b00;
  localparam logic [1:0]          C_ST_CRC_ERR  = 2'b01;
  localparam logic [1:0]          C_ST_TIMEOUT  = 2'b10;
  localparam logic [1:0]          C_ST_DATA_ERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HUNT  = 3'd1,
    S_TOKEN = 3'd2,
    S_DATA  = 3'd3,
    S_CRC   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [C_HUNT_W-1:0] r_hunt_cnt;
  logic [7:0]          r_shift;
  logic [3:0]          r_bit_cnt;
  logic [8:0]          r_byte_cnt;
  logic [15:0]         r_crc_rx;
  logic [7:0]          r_byte_data;
  logic                r_byte_valid;
  logic [8:0]          r_byte_index;
  logic [1:0]          r_status;

  logic [7:0]          w_shift_next;
  logic [15:0]         w_crc_rx_next;
  logic [1:0]          w_status_next;
  logic                w_byte_done;
  logic                w_crc_ok;

  assign w_shift_next  = {r_shift[6:0], rx.sd_data0};
  assign w_crc_rx_next = {r_crc_rx[14:0], rx.sd_data0};

`ifdef SD_RX_CRC_CHECK_EN
  logic [15:0] r_crc;
  logic [15:0] w_crc_next;
  logic        w_crc_fb;

  assign w_crc_fb   = r_crc[15] ^ rx.sd_data0;
  assign w_crc_next = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);
  assign w_crc_ok   = (w_crc_rx_next == r_crc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= '0;
    end else if (r_state == S_IDLE) begin
      r_crc <= '0;
    end else if (r_state == S_DATA && rx.sample_en) begin
      r_crc <= w_crc_next;
    end
  end
`else
  assign w_crc_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The hunt keeps an 8-bit window so a 0xFE preceded by idle ones is
  // recognised on its trailing 0; any other 0 opens a candidate token byte.
  always_comb begin
    w_state_next  = r_state;
    w_status_next = r_status;
    w_byte_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx.start) begin
          w_state_next  = S_HUNT;
          w_status_next = C_ST_OK;
        end
      end
      S_HUNT: begin
        if (rx.sample_en) begin
          if (w_shift_next == C_START_TOKEN) begin
            w_state_next = S_DATA;
          end else if (!rx.sd_data0) begin
            w_state_next = S_TOKEN;
          end else if (r_hunt_cnt >= C_HUNT_LAST) begin
            w_state_next  = S_DONE;
            w_status_next = C_ST_TIMEOUT;
          end
        end
      end
      S_TOKEN: begin
        if (rx.sample_en && r_bit_cnt == 4'd7) begin
          if (w_shift_next == C_START_TOKEN) begin
            w_state_next = S_DATA;
          end else if (w_shift_next[7:5] == 3'b000) begin
            w_state_next  = S_DONE;
            w_status_next = C_ST_DATA_ERR;
          end else begin
            w_state_next = S_HUNT;
          end
        end
      end
      S_DATA: begin
        if (rx.sample_en && r_bit_cnt[2:0] == 3'd7) begin
          w_byte_done = 1'b1;
          if (r_byte_cnt == C_LAST_BYTE) begin
            w_state_next = S_CRC;
          end
        end
      end
      S_CRC: begin
        if (rx.sample_en && r_bit_cnt == 4'd15) begin
          w_state_next  = S_DONE;
          w_status_next = w_crc_ok ? C_ST_OK : C_ST_CRC_ERR;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hunt_cnt   <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_crc_rx     <= '0;
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_byte_index <= '0;
      r_status     <= '0;
    end else begin
      r_byte_valid <= w_byte_done;
      r_status     <= w_status_next;
      if (w_byte_done) begin
        r_byte_data  <= w_shift_next;
        r_byte_index <= r_byte_cnt;
      end
      case (r_state)
        S_IDLE: begin
          r_hunt_cnt <= '0;
          r_shift    <= '0;
          r_bit_cnt  <= '0;
          if (rx.start) begin
            r_byte_cnt <= '0;
            r_crc_rx   <= '0;
          end
        end
        S_HUNT, S_TOKEN: begin
          if (rx.sample_en) begin
            r_shift <= w_shift_next;
            // Saturates so a long hunt with stray tokens cannot wrap past the limit
            if (r_hunt_cnt < C_HUNT_SAT) begin
              r_hunt_cnt <= r_hunt_cnt + 1'b1;
            end
            if (w_state_next == S_TOKEN) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else begin
              r_bit_cnt <= '0;
            end
          end
        end
        S_DATA: begin
          if (rx.sample_en) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= (r_bit_cnt[2:0] == 3'd7) ? 4'd0 : r_bit_cnt + 4'd1;
            if (w_byte_done && r_byte_cnt != C_LAST_BYTE) begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
        S_CRC: begin
          if (rx.sample_en) begin
            r_crc_rx  <= w_crc_rx_next;
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rx.busy       = (r_state != S_IDLE);
  assign rx.done       = (r_state == S_DONE);
  assign rx.byte_data  = r_byte_data;
  assign rx.byte_valid = r_byte_valid;
  assign rx.byte_index = r_byte_index;
  assign rx.status     = r_status;
  assign rx.crc_rx     = r_crc_rx;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_block_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sd_spi_block_rx : directed self-checking bench for sd_spi_block_rx |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module tb_sd_spi_block_rx;

`ifdef SD_RX_CRC_CHECK_EN
  localparam logic [1:0] C_BAD_CRC_ST = 2'b01;
`else
  localparam logic [1:0] C_BAD_CRC_ST = 2'b00;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sd_spi_block_rx_if bus ();

  sd_spi_block_rx #(
    .BLOCK_BYTES   (512),
    .TOKEN_TIMEOUT (800)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (bus)
  );

  always #5 clk = ~clk;

  int         n_checks  = 0;
  int         n_fail    = 0;
  int         nbytes    = 0;
  int         bad_bytes = 0;
  int         done_cnt  = 0;
  logic [7:0] exp_data [512];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.byte_valid) begin
      if (nbytes >= 512 || bus.byte_data !== exp_data[nbytes] || bus.byte_index !== 9'(nbytes))
        bad_bytes++;
      nbytes++;
    end
    if (bus.done) done_cnt++;
  end

  function automatic logic [15:0] crc16_model();
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = 0; i < 512; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ exp_data[i][b];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  task automatic clear_mon();
    nbytes    = 0;
    bad_bytes = 0;
  endtask

  task automatic send_bit(input logic b, input int gap);
    bus.sample_en = 1'b1;
    bus.sd_data0  = b;
    @(negedge clk);
    bus.sample_en = 1'b0;
    bus.sd_data0  = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], gap);
  endtask

  task automatic pulse_start(input logic with_sample, input logic smp_bit);
    bus.start     = 1'b1;
    bus.sample_en = with_sample;
    bus.sd_data0  = smp_bit;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.sample_en = 1'b0;
    bus.sd_data0  = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  bus.busy,       0);
    check({tag, "_done"},  bus.done,       0);
    check({tag, "_bval"},  bus.byte_valid, 0);
    check({tag, "_bdata"}, bus.byte_data,  0);
    check({tag, "_bidx"},  bus.byte_index, 0);
    check({tag, "_stat"},  bus.status,     0);
    check({tag, "_crc"},   bus.crc_rx,     0);
  endtask

  // Token, full payload from exp_data and CRC; the last CRC bit is followed
  // directly by the done check.
  task automatic run_block(input string tag, input logic [15:0] crc, input int gap,
                           input logic [1:0] exp_st, input int stray_at);
    int d0;
    d0 = done_cnt;
    send_bits(16'h00FE, 8, gap);
    for (int i = 0; i < 512; i++) begin
      if (i == stray_at) pulse_start(1'b0, 1'b1);
      send_bits({8'h00, exp_data[i]}, 8, gap);
    end
    send_bits(crc >> 1, 15, gap);
    send_bit(crc[0], 0);
    check({tag, "_done"},   bus.done,   1);
    check({tag, "_status"}, bus.status, 32'(exp_st));
    check({tag, "_crc_rx"}, bus.crc_rx, 32'(crc));
    check({tag, "_busy"},   bus.busy,   1);
    @(negedge clk);
    check({tag, "_done_lo"}, bus.done,       0);
    check({tag, "_idle"},    bus.busy,       0);
    check({tag, "_nbytes"},  nbytes,         512);
    check({tag, "_bytes"},   bad_bytes,      0);
    check({tag, "_ndone"},   done_cnt - d0,  1);
  endtask

  initial begin
    int d0;
    bus.start     = 1'b0;
    bus.sample_en = 1'b0;
    bus.sd_data0  = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Zero payload after 20 idle ones, one strobe per four cycles
    for (int i = 0; i < 512; i++) exp_data[i] = 8'h00;
    clear_mon();
    pulse_start(1'b0, 1'b1);
    check("zero_busy_rise", bus.busy, 1);
    repeat (20) send_bit(1'b1, 3);
    run_block("zero", 16'h0000, 3, 2'b00, -1);

    // All-ones payload, back-to-back strobes, good CRC
    for (int i = 0; i < 512; i++) exp_data[i] = 8'hFF;
    clear_mon();
    pulse_start(1'b0, 1'b1);
    send_bits(16'h00FF, 8, 0);
    run_block("ff_ok", 16'h7FA1, 0, 2'b00, -1);

    // All-ones payload with a corrupted CRC
    clear_mon();
    pulse_start(1'b0, 1'b1);
    run_block("ff_bad", 16'h7FA0, 1, C_BAD_CRC_ST, -1);

    // Token timeout: 800 hunt strobes with the line high
    clear_mon();
    pulse_start(1'b0, 1'b1);
    repeat (799) send_bit(1'b1, 0);
    check("to_early_done", bus.done, 0);
    send_bit(1'b1, 0);
    check("to_done",   bus.done,   1);
    check("to_status", bus.status, 2'b10);
    @(negedge clk);
    check("to_idle",   bus.busy,   0);
    check("to_nbytes", nbytes,     0);

    // Data error token 0x09; the sample coinciding with start must be dropped
    clear_mon();
    pulse_start(1'b1, 1'b0);
    repeat (5) send_bit(1'b1, 1);
    send_bits(16'h0004, 7, 1);
    send_bit(1'b1, 0);
    check("derr_done",   bus.done,   1);
    check("derr_status", bus.status, 2'b11);
    repeat (3) @(negedge clk);
    check("derr_hold",   bus.status, 2'b11);
    check("derr_nbytes", nbytes,     0);

    // Stray 0x7F before a real token, incrementing payload
    for (int i = 0; i < 512; i++) exp_data[i] = 8'(i);
    clear_mon();
    pulse_start(1'b0, 1'b1);
    send_bits(16'h007F, 8, 1);
    run_block("inc", crc16_model(), 1, 2'b00, -1);

    // Reset after byte 100, then a clean block with an ignored mid-block start
    clear_mon();
    d0 = done_cnt;
    pulse_start(1'b0, 1'b1);
    send_bits(16'h00FE, 8, 0);
    for (int i = 0; i <= 100; i++) send_bits({8'h00, exp_data[i]}, 8, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    check("midrst_nbytes", nbytes,        101);
    check("midrst_nodone", done_cnt - d0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    clear_mon();
    pulse_start(1'b0, 1'b1);
    repeat (3) send_bit(1'b1, 0);
    run_block("after_rst", crc16_model(), 0, 2'b00, 37);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sd_spi_block_rx.md
# sd_spi_block_rx

Receives one 512-byte SD data block in 1-bit SPI mode on `sd_data0` after the command engine has issued CMD17 and accepted its R1 response. The block:
- hunts for the start token;
- delivers payload bytes one per strobe to a downstream byte sink (buffer or UART debug path);
- checks the trailing CRC16;
- reports one completion status.

It sits between the SD command/init engine (which owns `sd_cclk`, `sd_cs`, `sd_cmd`) and the block-data consumer.

## Interface
Parameters:
- `BLOCK_BYTES`, 512, payload bytes per block.
- `TOKEN_TIMEOUT`, 800, max `sample_en` strobes spent hunting for a token before giving up.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse; arms a block receive.
- `sample_en`  in  1  one-cycle strobe marking an `sd_cclk` rising edge; `sd_data0` is sampled only in that cycle.
- `sd_data0`  in  1  card data-out line.
- `busy`  out  1  high from the cycle after an accepted `start` until the `done` cycle inclusive.
- `byte_data`  out  8  received payload byte, MSB first on the wire.
- `byte_valid`  out  1  one-cycle qualifier for `byte_data`/`byte_index`.
- `byte_index`  out  9  payload byte position, 0..BLOCK_BYTES-1.
- `done`  out  1  one-cycle pulse at end of receive.
- `status`  out  2  valid from `done` until the next accepted `start`:
  - 00 ok
  - 01 CRC error
  - 10 token timeout
  - 11 data error token
- `crc_rx`  out  16  CRC16 as received from the card (debug).

## Operation
- States: IDLE, HUNT, TOKEN, DATA, CRC, DONE.
- IDLE:
  - `start` moves to HUNT.
  - Clear the hunt counter and CRC accumulator.
  - `sample_en` is ignored.
- HUNT:
  - On each `sample_en`, increment the hunt counter.
  - `sd_data0`=0 moves to TOKEN; that 0 is bit 7 of the token byte.
  - If the hunt counter reaches TOKEN_TIMEOUT while still in HUNT, set status 10 and go to DONE.
- TOKEN:
  - Shift in 7 more bits.
  - Byte == 8'hFE: go to DATA.
  - Byte[7:5] == 3'b000: data error token; set status 11 and go to DONE.
  - Any other byte: return to HUNT. The hunt counter keeps running across TOKEN, so timeout still applies.
- DATA:
  - Shift in bits MSB first.
  - Every 8th bit, emit the byte with its index.
  - After byte BLOCK_BYTES-1, go to CRC.
- CRC:
  - Shift 16 bits MSB first into `crc_rx`.
  - After the 16th bit, compare against the accumulated CRC and go to DONE.
- DONE: pulse `done`, drop `busy`, go to IDLE.
- CRC16: CCITT, polynomial 0x1021, init 0x0000, bitwise per sampled payload bit. It covers payload bits only, not the token.
- `start` while `busy`: ignored.
- `start` and `sample_en` in the same IDLE cycle: start accepted, that sample discarded.

## Timing
- Reset values (async, immediate): state IDLE, and every output 0. That is `busy`, `byte_data`, `byte_valid`, `byte_index`, `done`, `status`, `crc_rx` all 0.
- `busy` rises 1 cycle after `start`.
- `byte_valid` is asserted in the cycle after the `sample_en` that captured the byte's 8th bit, for exactly 1 cycle.
- `byte_data`/`byte_index` hold until the next byte.
- `done` is asserted 1 cycle after the deciding sample (16th CRC bit, 8th token bit, or timeout strobe). `status` is updated in that same cycle.
- Back-to-back `sample_en` on consecutive cycles must be supported (25 MHz at divide-by-4 gives a worst case of 1 strobe per 4 cycles; design for 1 per cycle).
- Reset mid-operation: abort immediately; no `done` pulse.
- `byte_index` wraps only via a new `start`; it never exceeds BLOCK_BYTES-1.

## Configuration
- `SD_RX_CRC_CHECK_EN` defined: CRC accumulator and compare present; status 01 is possible.
- Not defined:
  - No CRC logic.
  - The 16 CRC bits are still consumed into `crc_rx` and `done` timing is unchanged.
  - Status is never 01.

## Test plan
- 0xFF idle for 20 strobes, then 0xFE, 512 × 8'h00, CRC 16'h0000:
  - 512 `byte_valid` pulses with data 0 and indices 0..511.
  - `done` with status 00.
  - `crc_rx`=0000.
- 0xFE, 512 × 8'hFF, CRC 16'h7FA1: status 00. The same with CRC 16'h7FA0: status 01 (00 when `SD_RX_CRC_CHECK_EN` is undefined).
- Line held 1 for 800 strobes: `done` 1 cycle after the 800th strobe, status 10, zero `byte_valid`.
- Token 8'h09 after 5 idle bits: status 11, no `byte_valid`, `done` 1 cycle after the token's 8th bit.
- Stray byte 8'h7F (leading 0, not a token), then 0xFE and an incrementing-pattern block with correct CRC: stray byte ignored, 512 bytes 0x00..0xFF repeating, status 00.
- `rst_n` low after byte 100: all outputs 0 immediately, no `done`. A following `start` receives a full block normally. A `start` issued while `busy` is ignored.
